// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the RV32 func3 encodings, the legal window defaults, the FSM states and the request record.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 32;

   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   localparam logic [15:0] DMEM_BASE_DEF = 16'h2000;
   localparam logic [15:0] DMEM_END_DEF  = 16'h3FFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dmem_arb_state_e;

   typedef struct packed {
      logic                   wren;
      logic [2:0]             func3;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [31:0]            wdata;
   } dmem_req_t;

   // Range, alignment and opcode qualification of one access; only addr[15:0] selects the window.
   function automatic logic dmem_access_err(input logic       wren,
                                            input logic [2:0] func3,
                                            input logic [15:0] addr_lo,
                                            input logic [15:0] base,
                                            input logic [15:0] dmem_end);
      logic [2:0]  v_size;
      logic [16:0] v_last_byte;
      logic        v_legal;
      logic        v_err;
      case (func3[1:0])
         2'b00:   v_size = 3'd1;
         2'b01:   v_size = 3'd2;
         default: v_size = 3'd4;
      endcase
      v_last_byte = {1'b0, addr_lo} + {14'd0, v_size} - 17'd1;
      if (wren) begin
         v_legal = (func3 == SB) || (func3 == SH) || (func3 == SW);
      end else begin
         v_legal = (func3 == LB) || (func3 == LH) || (func3 == LW) ||
                   (func3 == LBU) || (func3 == LHU);
      end
      v_err = (addr_lo < base) ||
              (v_last_byte > {1'b0, dmem_end}) ||
              ((func3[1:0] == 2'b01) && (addr_lo[0] != 1'b0)) ||
              ((func3[1:0] == 2'b10) && (addr_lo[1:0] != 2'b00)) ||
              !v_legal;
      return v_err;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not served last.
module rr_arb2 (
   input  logic [1:0] i_valid,
   input  logic       i_rr_last,
   output logic [1:0] o_grant
);

   // One-hot grant selection
   always_comb begin
      case (i_valid)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = i_rr_last ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing data_mem between the core LSU (port 0) and DMA/debug (port 1).
// One request per three cycles: grant in IDLE, memory access in ACCESS, response pulse in RESP.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter logic [15:0] DMEM_BASE = DMEM_BASE_DEF,
   parameter logic [15:0] DMEM_END  = DMEM_END_DEF,
   parameter int          ADDR_W    = DMEM_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_req_valid,
   output logic [1:0]        o_req_ready,
   input  logic [1:0]        i_req_wren,
   input  logic [2:0]        i_req_func3 [2],
   input  logic [ADDR_W-1:0] i_req_addr  [2],
   input  logic [31:0]       i_req_wdata [2],
   output logic [1:0]        o_rsp_valid,
   output logic              o_rsp_err,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_mem_wren,
   output logic [2:0]        o_mem_func3,
   output logic [31:0]       o_mem_addr,
   output logic [31:0]       o_mem_st_data,
   input  logic [31:0]       i_mem_ld_data
);

   dmem_arb_state_e r_state;
   dmem_arb_state_e w_next_state;
   dmem_req_t       r_req;
   logic            r_rr_last;
   logic            r_port;
   logic            r_err;
   logic [31:0]     r_rdata;
   logic [1:0]      w_grant;
   logic            w_take;
   logic            w_port;
   logic            w_err;

   rr_arb2 u_rr_arb2 (
      .i_valid   (i_req_valid),
      .i_rr_last (r_rr_last),
      .o_grant   (w_grant)
   );

   assign w_take = |(i_req_valid & o_req_ready);
   assign w_port = w_grant[1];
   assign w_err  = dmem_access_err(r_req.wren, r_req.func3, r_req.addr[15:0], DMEM_BASE, DMEM_END);

   // The latched request drives data_mem directly, so these hold between accesses
   assign o_mem_func3   = r_req.func3;
   assign o_mem_addr    = r_req.addr;
   assign o_mem_st_data = r_req.wdata;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = IDLE;
      case (r_state)
         IDLE:    w_next_state = w_take ? ACCESS : IDLE;
         ACCESS:  w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Outputs; the ~i_rst term kills a write when reset lands on the ACCESS cycle
   always_comb begin
      o_req_ready = 2'b00;
      o_rsp_valid = 2'b00;
      o_rsp_err   = 1'b0;
      o_rsp_rdata = 32'd0;
      o_mem_wren  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!i_rst) begin
               o_req_ready = w_grant;
            end else begin
               o_req_ready = 2'b00;
            end
         end
         ACCESS: begin
            o_mem_wren = r_req.wren & ~w_err & ~i_rst;
         end
         RESP: begin
            o_rsp_valid = r_port ? 2'b10 : 2'b01;
            o_rsp_err   = r_err;
            o_rsp_rdata = r_rdata;
         end
         default: begin
            o_req_ready = 2'b00;
         end
      endcase
   end

   // Request latch, round-robin history and response registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr_last   <= 1'b1;
         r_port      <= 1'b0;
         r_req.wren  <= 1'b0;
         r_req.func3 <= SW;
         r_req.addr  <= '0;
         r_req.wdata <= 32'd0;
         r_err       <= 1'b0;
         r_rdata     <= 32'd0;
      end else begin
         if (w_take) begin
            r_rr_last   <= w_port;
            r_port      <= w_port;
            r_req.wren  <= i_req_wren[w_port];
            r_req.func3 <= i_req_func3[w_port];
            r_req.addr  <= i_req_addr[w_port];
            r_req.wdata <= i_req_wdata[w_port];
         end
         if (r_state == ACCESS) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_req.wren) ? 32'd0 : i_mem_ld_data;
         end
      end
   end

endmodule
